// File: rtl/sd_access_arbiter.sv
// sd_access_arbiter: shares one SPI microSD controller between requester A
// (boot loader) and requester B (debug/host). One single-word read or write
// is in flight at a time; grants alternate when both ask together.
//
// Ports
//   control_clk_i / control_rst_i : clock, synchronous active-high reset
//   a_* / b_*                     : requester handshakes (req/we/addr/wdata in,
//                                   ack/err/rdata out)
//   sd_*_o                        : address, write data, we/re and nextoper to
//                                   the controller
//   sd_done_i / sd_rdata_i        : controller idle level and read data
//   grant_o                       : last/current grant (0=A, 1=B)
//   busy_o                        : operation in progress
//   timeout_o                     : sticky, set by any aborted operation
module sd_access_arbiter #(
  parameter int unsigned     TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(2000000)
) (
  input  logic        control_clk_i,
  input  logic        control_rst_i,

  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_ack_o,
  output logic        a_err_o,
  output logic [31:0] a_rdata_o,

  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_ack_o,
  output logic        b_err_o,
  output logic [31:0] b_rdata_o,

  output logic [31:0] sd_address_o,
  output logic [31:0] sd_dataw_o,
  output logic        sd_we_o,
  output logic        sd_re_o,
  output logic        sd_nextoper_o,
  input  logic        sd_done_i,
  input  logic [31:0] sd_rdata_i,

  output logic        grant_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]      state_q,      state_d;
  logic            first_done_q, first_done_d;
  logic            grant_q,      grant_d;
  logic [31:0]     addr_q,       addr_d;
  logic [31:0]     dataw_q,      dataw_d;
  logic            we_q,         we_d;
  logic            re_q,         re_d;
  logic            nextoper_q,   nextoper_d;
  logic [31:0]     a_rdata_q,    a_rdata_d;
  logic [31:0]     b_rdata_q,    b_rdata_d;
  logic            a_ack_q,      a_ack_d;
  logic            b_ack_q,      b_ack_d;
  logic            a_err_q,      a_err_d;
  logic            b_err_q,      b_err_d;
  logic            timeout_q,    timeout_d;
  logic            busy_q,       busy_d;
  logic [TO_W-1:0] cnt_q,        cnt_d;

  logic            sel;
  logic            sel_we;
  logic            timeout_hit;

  // Winner of this arbitration round: alternate on contention.
  assign sel         = (a_req_i & b_req_i) ? ~grant_q : b_req_i;
  assign sel_we      = sel ? b_we_i : a_we_i;
  assign timeout_hit = (cnt_q == (TIMEOUT_CYCLES - TO_W'(1)));

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    first_done_d = first_done_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    dataw_d      = dataw_q;
    we_d         = we_q;
    re_d         = re_q;
    nextoper_d   = nextoper_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    b_err_d      = 1'b0;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (a_req_i | b_req_i) begin
          grant_d = sel;
          addr_d  = sel ? b_addr_i  : a_addr_i;
          dataw_d = sel ? b_wdata_i : a_wdata_i;
          we_d    = sel_we;
          re_d    = ~sel_we;
          cnt_d   = '0;
          // The controller picks up we/re by itself at the end of init,
          // so the very first operation skips the nextoper handshake.
          if (first_done_q) begin
            state_d    = S_ISSUE;
            nextoper_d = 1'b1;
          end else begin
            state_d    = S_WAIT;
          end
        end
      end

      S_ISSUE: begin
        cnt_d = cnt_q + TO_W'(1);
        if (timeout_hit) begin
          nextoper_d = 1'b0;
          a_ack_d    = ~grant_q;
          b_ack_d    = grant_q;
          a_err_d    = ~grant_q;
          b_err_d    = grant_q;
          timeout_d  = 1'b1;
          state_d    = S_ACK;
        end else if (!sd_done_i) begin
          // Controller has left its idle state: the operation is accepted.
          nextoper_d = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // Completion takes priority over a coincident timeout.
        if (sd_done_i) begin
          if (re_q) begin
            if (grant_q) b_rdata_d = sd_rdata_i;
            else         a_rdata_d = sd_rdata_i;
          end
          a_ack_d = ~grant_q;
          b_ack_d = grant_q;
          state_d = S_ACK;
        end else if (timeout_hit) begin
          a_ack_d   = ~grant_q;
          b_ack_d   = grant_q;
          a_err_d   = ~grant_q;
          b_err_d   = grant_q;
          timeout_d = 1'b1;
          state_d   = S_ACK;
        end
      end

      S_ACK: begin
        we_d = 1'b0;
        re_d = 1'b0;
        // An aborted first operation leaves the init-path flag untouched.
        if (!(a_err_q | b_err_q)) first_done_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge control_clk_i) begin
    if (control_rst_i) begin
      state_q      <= S_IDLE;
      first_done_q <= 1'b0;
      grant_q      <= 1'b1;
      addr_q       <= '0;
      dataw_q      <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      nextoper_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      first_done_q <= first_done_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      dataw_q      <= dataw_d;
      we_q         <= we_d;
      re_q         <= re_d;
      nextoper_q   <= nextoper_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_err_q      <= a_err_d;
      b_err_q      <= b_err_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign a_ack_o       = a_ack_q;
  assign a_err_o       = a_err_q;
  assign a_rdata_o     = a_rdata_q;
  assign b_ack_o       = b_ack_q;
  assign b_err_o       = b_err_q;
  assign b_rdata_o     = b_rdata_q;
  assign sd_address_o  = addr_q;
  assign sd_dataw_o    = dataw_q;
  assign sd_we_o       = we_q;
  assign sd_re_o       = re_q;
  assign sd_nextoper_o = nextoper_q;
  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;

endmodule
